// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus port for mmio_uart_tx.
// The core drives the master side; the UART decodes on the slave side.
interface mmio_uart_tx_if #(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32
);
  logic                         i_mem_wr_en;
  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr;
  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data;
  logic                         o_sel;
  logic [DATA_WIDTH_P-1:0]      o_rd_data;

  modport master (
    output i_mem_wr_en,
    output i_mem_addr,
    output i_mem_wr_data,
    input  o_sel,
    input  o_rd_data
  );

  modport slave (
    input  i_mem_wr_en,
    input  i_mem_addr,
    input  i_mem_wr_data,
    output o_sel,
    output o_rd_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA store -> FIFO -> 8N1 serializer, STATUS read.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module mmio_uart_tx #(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter logic [DATA_ADDR_WIDTH_P-1:0] BASE_ADDR_P = 32'h0000_0100,
  parameter int CLKS_PER_BIT_P    = 217,
  parameter int FIFO_ADDR_WIDTH_P = 3
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          o_tx
);

  localparam int DEPTH_LP = 1 << FIFO_ADDR_WIDTH_P;
  localparam int CW_LP    = FIFO_ADDR_WIDTH_P + 1;
  localparam int BW_LP    = $clog2(CLKS_PER_BIT_P);
  localparam int AW_LP    = FIFO_ADDR_WIDTH_P;

  localparam logic [DATA_ADDR_WIDTH_P-1:0] STAT_ADDR_LP =
    BASE_ADDR_P + DATA_ADDR_WIDTH_P'(4);
  localparam logic [BW_LP-1:0] BAUD_MAX_LP =
    BW_LP'(CLKS_PER_BIT_P - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN_LP = 1'b1;
`else
  localparam logic PAR_EN_LP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;

  logic [7:0]        mem_q [DEPTH_LP];
  logic [AW_LP-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW_LP-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW_LP-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  state_e            state_q;
  logic [BW_LP-1:0]  baud_q;
  logic [2:0]        idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  logic sel_tx, sel_st;
  logic full, empty, busy;
  logic pop, push_req, push_ok, tick;
  logic [DATA_WIDTH_P-1:0] rd_data;
  logic unused_wdata;

  assign sel_tx   = bus.i_mem_addr == BASE_ADDR_P;
  assign sel_st   = bus.i_mem_addr == STAT_ADDR_LP;
  assign full     = count_q == CW_LP'(DEPTH_LP);
  assign empty    = count_q == '0;
  assign busy     = state_q != IDLE;
  assign tick     = baud_q == BAUD_MAX_LP;
  assign pop      = (state_q == IDLE) && !empty;
  assign push_req = bus.i_mem_wr_en && sel_tx;
  // A full FIFO still takes the byte when the head leaves the same cycle.
  assign push_ok  = push_req && (!full || pop);

  assign unused_wdata = ^bus.i_mem_wr_data[DATA_WIDTH_P-1:8];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    count_d  = count_q + CW_LP'(push_ok) - CW_LP'(pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW_LP'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW_LP'(1);
    if (bus.i_mem_wr_en && sel_st) begin
      ovf_d = 1'b0;
    end else if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.i_mem_wr_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^mem_q[rd_ptr_q];
`endif
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW_LP'(1);
          end
        end
        DATA: begin
          if (tick) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW_LP'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BW_LP'(1);
          end
        end
`endif
        STOP: begin
          if (tick) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BW_LP'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_st) begin
      rd_data[0]            = busy;
      rd_data[1]            = full;
      rd_data[2]            = empty;
      rd_data[3]            = ovf_q;
      rd_data[4]            = PAR_EN_LP;
      rd_data[8 +: CW_LP]   = count_q;
    end
  end

  assign bus.o_sel     = sel_tx | sel_st;
  assign bus.o_rd_data = rd_data;
  assign o_tx          = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: random stores vs a timeline model.
// A monitor captures each frame off o_tx and checks it against the queue.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] STAT = 32'h0000_0104;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PBIT = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif
  localparam int FL = NB * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  mmio_uart_tx_if #(.DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32)) bus ();

  mmio_uart_tx #(
    .DATA_WIDTH_P(32),
    .DATA_ADDR_WIDTH_P(32),
    .BASE_ADDR_P(BASE),
    .CLKS_PER_BIT_P(C),
    .FIFO_ADDR_WIDTH_P(3)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus),
    .o_tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  // Model: every accepted byte with the edge it was stored and popped.
  frame_t exp_q[$];
  int     m_store[$];
  int     m_pop[$];
  int     last_pop;
  bit     m_ovf;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_store.delete();
    m_pop.delete();
    last_pop = -1000;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_store(input logic [7:0] d, input int e);
    int occ = 0;
    bit popnow = 1'b0;
    int p;
    foreach (m_pop[i]) begin
      if (m_pop[i] >= e) occ++;
      if (m_pop[i] == e) popnow = 1'b1;
    end
    if (occ < DEPTH || popnow) begin
      p = (e + 1 > last_pop + FL + 1) ? e + 1 : last_pop + FL + 1;
      m_store.push_back(e);
      m_pop.push_back(p);
      last_pop = p;
      exp_q.push_back('{data: d, start: p});
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_status(input int e);
    int cnt = 0;
    bit bsy = 1'b0;
    logic [31:0] s;
    foreach (m_pop[i]) begin
      if (m_store[i] <= e && m_pop[i] > e) cnt++;
      if (m_pop[i] <= e && e < m_pop[i] + FL) bsy = 1'b1;
    end
    s = PBIT;
    s[0] = bsy;
    s[1] = (cnt == DEPTH);
    s[2] = (cnt == 0);
    s[3] = m_ovf;
    s[11:8] = cnt[3:0];
    return s;
  endfunction

  function automatic logic [63:0] frame_bits(input logic [7:0] d);
    logic [63:0] v = '1;
    for (int n = 0; n < FL; n++) begin
      int b = n / C;
      if (b == 0)                  v[n] = 1'b0;
      else if (b <= 8)             v[n] = d[b-1];
      else if (b == 9 && NB == 11) v[n] = ^d;
      else                         v[n] = 1'b1;
    end
    return v;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.i_mem_wr_en   = 1'b1;
    bus.i_mem_addr    = a;
    bus.i_mem_wr_data = d;
    if (a == BASE)      model_store(d[7:0], cyc + 1);
    else if (a == STAT) m_ovf = 1'b0;
    @(negedge clk);
    bus.i_mem_wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [31:0] a, input string nm);
    logic [31:0] er;
    bit es;
    bus.i_mem_wr_en   = 1'b0;
    bus.i_mem_addr    = a;
    bus.i_mem_wr_data = $urandom;
    #1;
    es = (a == BASE) || (a == STAT);
    er = (a == STAT) ? exp_status(cyc) : 32'h0;
    check({nm, "_sel"}, 64'(bus.o_sel), 64'(es));
    check({nm, "_rd"}, 64'(bus.o_rd_data), 64'(er));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain();
    int lim = 0;
    while ((exp_q.size() != 0 || cyc <= last_pop + FL) && lim < 3000) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    logic [63:0] smp;
    int st;
    bit ok;
    frame_t f;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        smp = '1;
        smp[0] = 1'b0;
        st = cyc;
        ok = 1'b1;
        for (int n = 1; n < FL; n++) begin
          @(negedge clk);
          if (!mon_en || !rst_n) begin
            ok = 1'b0;
            break;
          end
          smp[n] = tx;
        end
        if (ok) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0h required=none", smp);
          end else begin
            f = exp_q.pop_front();
            check("frame_start", 64'(st), 64'(f.start));
            check("frame_bits", smp, frame_bits(f.data));
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int op;
    bit lowseen;
    logic [7:0] rb;
    bus.i_mem_wr_en   = 1'b0;
    bus.i_mem_addr    = '0;
    bus.i_mem_wr_data = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx), 64'(1));
    read_chk(STAT, "reset_status");
    check("reset_status_const", 64'(bus.o_rd_data), 64'(32'h4 | PBIT));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx", 64'(tx), 64'(1));
    read_chk(STAT, "status_after_reset");
    read_chk(BASE, "txdata_read");
    read_chk(32'h108, "other_addr");
    mon_en = 1'b1;

    do_write(BASE, 32'hDEAD_BEA5);
    p = last_pop;
    wait_cyc(p + FL - 1);
    read_chk(STAT, "busy_last");
    wait_cyc(p + FL);
    read_chk(STAT, "busy_clear");
    wait_drain();

    for (int i = 0; i < 10; i++)
      do_write(BASE, (32'($urandom) & 32'hFFFF_FF00) | 32'(i));
    read_chk(STAT, "fill_status");
    check("fill_status_const", 64'(bus.o_rd_data), 64'(32'h80B | PBIT));
    do_write(STAT, $urandom);
    read_chk(STAT, "ovf_clear");
    check("ovf_clear_bit", 64'(bus.o_rd_data[3]), 64'(0));
    wait_drain();
    read_chk(STAT, "drain_status");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        do_write(BASE, $urandom);
      end else if (op == 6) begin
        do_write(STAT, $urandom);
      end else if (op == 7) begin
        do_write(32'h200 + 32'($urandom_range(0, 15) << 2), $urandom);
      end else begin
        read_chk(STAT, "rand_status");
        @(negedge clk);
      end
      repeat ($urandom_range(0, FL / 2)) @(negedge clk);
    end
    wait_drain();
    read_chk(STAT, "rand_drain_status");

    mon_en = 1'b0;
    rb = 8'hF0;
    do_write(BASE, 32'(rb));
    p = last_pop;
    do_write(BASE, 32'h5A);
    do_write(BASE, 32'h33);
    wait_cyc(p + 4 * C + 1);
    check("bit3_tx", 64'(tx), 64'(rb[3]));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", 64'(tx), 64'(1));
    model_reset();
    read_chk(STAT, "rst_mid_status");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lowseen = 1'b0;
    repeat (2 * FL) begin
      @(negedge clk);
      if (tx !== 1'b1) lowseen = 1'b1;
    end
    check("no_frame_after_reset", 64'(lowseen), 64'(0));
    read_chk(STAT, "post_reset_status");

    mon_en = 1'b1;
    do_write(BASE, 32'h07);
    wait_drain();
    read_chk(STAT, "final_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory bus, downstream of the core alongside the data memory. Stores to its TXDATA address push a byte into a transmit FIFO. A serializer drains the FIFO onto `o_tx` as 8N1 frames, LSB first. A STATUS word is returned combinationally on reads, matching the core's same-cycle read contract.

## Interface
Parameters:
- DATA_WIDTH_P, 32, bus data width.
- DATA_ADDR_WIDTH_P, 32, bus address width.
- BASE_ADDR_P, 32'h0000_0100, byte address of TXDATA; STATUS is at BASE_ADDR_P+4.
- CLKS_PER_BIT_P, 217, clocks per UART bit (25 MHz / 115200); minimum 2.
- FIFO_ADDR_WIDTH_P, 3, FIFO depth = 2^FIFO_ADDR_WIDTH_P; maximum 4.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, asynchronous, active-low reset.
- i_mem_wr_en, input, 1, store strobe from the core.
- i_mem_addr, input, DATA_ADDR_WIDTH_P, byte address from the core.
- i_mem_wr_data, input, DATA_WIDTH_P, store data from the core.
- o_sel, output, 1, combinational; high when i_mem_addr equals TXDATA or STATUS. The bus mux uses it to select o_rd_data over the data memory.
- o_rd_data, output, DATA_WIDTH_P, combinational read data.
- o_tx, output, 1, serial line; idles high.

## Operation
- Write, TXDATA (i_mem_wr_en && addr==BASE):
  - Push i_mem_wr_data[7:0]; upper bits are ignored.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky `ovf` is set.
  - A push into a full FIFO in the same cycle as a pop is accepted; count is unchanged.
- Write, STATUS: clears `ovf`. Data is ignored.
- Read, STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 ovf, bits [8 +: FIFO_ADDR_WIDTH_P+1] count; all other bits are 0.
- Read, TXDATA: returns 0.
- Any address other than TXDATA or STATUS: o_sel=0, o_rd_data=0, writes ignored.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo depth.
  - count ranges 0..depth; full = (count==depth), empty = (count==0).
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if !empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT_P cycles, then DATA with bit index 0.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT_P cycles, shift right, index++. After index 7 completes, go to STOP (or PARITY).
  - STOP: o_tx=1 for CLKS_PER_BIT_P cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT_P-1; wraps to 0 on each bit advance.
- o_tx is registered.

## Timing
- Reset (asserted asynchronously, at any time including mid-frame):
  - o_tx=1, FSM=IDLE, FIFO empty (pointers 0, count 0), ovf=0, baud counter 0.
  - o_sel and o_rd_data are combinational and show empty status immediately.
- Push latency: a store at edge N is visible in count after edge N.
- Pop latency: a pop happens at the first edge where the FSM is IDLE and the FIFO is non-empty; o_tx falls at that same edge.
- An isolated byte therefore starts 1 cycle after its store edge.
- Frame length: 10×CLKS_PER_BIT_P cycles (11× with parity).
- Back-to-back frames: one IDLE cycle between the end of STOP and the next START.
- busy is high from the pop edge until the edge that returns the FSM to IDLE.

## Configuration
- Macro UART_TX_PARITY_EN.
  - Defined: a PARITY state follows DATA. o_tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT_P cycles, then STOP. STATUS bit4 reads 1.
  - Undefined: 8N1 framing only. STATUS bit4 reads 0.

## Test plan
- Reset, CLKS_PER_BIT_P=4:
  - Stimulus: release reset; read STATUS.
  - Required: o_tx=1 and STATUS=32'h0000_0004 (empty only).
- Single byte:
  - Stimulus: store 0xA5 to 0x100.
  - Required: o_tx low 4 cycles starting one edge later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy clears after 40 cycles.
- Fill/overflow, FIFO_ADDR_WIDTH_P=3:
  - Stimulus: issue 10 consecutive stores 0x00..0x09.
  - Required: the first is popped immediately, 8 are queued, and 0x09 is dropped. STATUS shows full=1, ovf=1, count=8.
  - Stimulus: store to 0x104.
  - Required: ovf=0.
- Drain order: after the fill test, bytes 0x00..0x08 appear on o_tx in order, with a 1-cycle IDLE gap between frames. Final STATUS: empty=1, count=0.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3.
  - Required: o_tx=1 within the same cycle, FIFO empty, no further frame after release.
- Parity build (UART_TX_PARITY_EN):
  - Stimulus: send 0x07.
  - Required: parity bit=1, frame length 44 cycles.
